// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Purpose : Shared definitions for the AXI4-Lite load/store unit: memory op
//           encodings, FSM state encoding, AXI response codes and small op
//           classification helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // EXU op encodings; 8..15 carry no memory access.
  localparam logic [3:0] LSU_LB   = 4'd0;
  localparam logic [3:0] LSU_LH   = 4'd1;
  localparam logic [3:0] LSU_LW   = 4'd2;
  localparam logic [3:0] LSU_LBU  = 4'd3;
  localparam logic [3:0] LSU_LHU  = 4'd4;
  localparam logic [3:0] LSU_SB   = 4'd5;
  localparam logic [3:0] LSU_SH   = 4'd6;
  localparam logic [3:0] LSU_SW   = 4'd7;
  localparam logic [3:0] LSU_NONE = 4'd8;

  // AXI response codes.
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op <= LSU_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= LSU_SB) && (op <= LSU_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_axil_if.sv
`default_nettype none
// ============================================================================
// Module  : lsu_axil_if
// Purpose : Bundles the EXU request, WBU result and AXI4-Lite master channels
//           of the load/store unit.
// Ports   : none; modport master = LSU view (drives in_ready, out_*, AR/AW/W
//           valids, rready, bready), modport slave = environment view.
// Revision: 1.0 - initial release
// ============================================================================
interface lsu_axil_if #(
  parameter int XLEN  = 32,
  parameter int BUS_W = 32
);
  import lsu_pkg::*;

  localparam int STRB_W = BUS_W / 8;

  // EXU -> LSU
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  // LSU -> WBU
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic              out_err;
  // AXI4-Lite read
  logic [XLEN-1:0]   araddr;
  logic              arvalid;
  logic              arready;
  logic [BUS_W-1:0]  rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  // AXI4-Lite write
  logic [XLEN-1:0]   awaddr;
  logic              awvalid;
  logic              awready;
  logic [BUS_W-1:0]  wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  in_valid, in_op, in_addr, in_wdata, out_ready,
           arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    output in_ready, out_valid, out_data, out_err,
           araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

  modport slave (
    output in_valid, in_op, in_addr, in_wdata, out_ready,
           arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    input  in_ready, out_valid, out_data, out_err,
           araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

endinterface
`default_nettype wire

// File: rtl/lsu_axil_lane.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane
// Purpose : Combinational byte-lane steering for the load/store unit.
//           Store side builds wdata/wstrb; load side shifts the bus word down
//           to the addressed byte and sign/zero extends it.
// Ports   : op_i      - captured memory op
//           off_i     - byte offset within the bus word
//           st_data_i - store data (rs2)
//           ld_bus_i  - raw AXI read data
//           wdata_o   - store data replicated across lanes
//           wstrb_o   - store byte strobes
//           ld_data_o - extended load result
// Revision: 1.0 - initial release
// ============================================================================
module lsu_lane
  import lsu_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int BUS_W  = 32,
  localparam int STRB_W = BUS_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [3:0]        op_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [BUS_W-1:0]  ld_bus_i,
  output logic [BUS_W-1:0]  wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [STRB_W-1:0] base_strb;
  logic [31:0]       ld_word;

  // Replicating the access-sized datum across every lane puts the right bytes
  // under the strobes whatever the offset, so no data shifter is needed.
  always_comb begin
    base_strb = '0;
    wdata_o   = {(BUS_W/32){st_data_i[31:0]}};
    case (op_i)
      LSU_SB: begin
        base_strb[0] = 1'b1;
        wdata_o      = {STRB_W{st_data_i[7:0]}};
      end
      LSU_SH: begin
        base_strb[1:0] = 2'b11;
        wdata_o        = {(STRB_W/2){st_data_i[15:0]}};
      end
      LSU_SW: base_strb[3:0] = 4'hF;
      default: ;
    endcase
  end

  // Strobes for an access crossing the bus word fall off the top and are lost.
  assign wstrb_o = base_strb << off_i;

  // Only the low word of the shifted bus data is ever consumed.
  assign ld_word = 32'(ld_bus_i >> {off_i, 3'b000});

  always_comb begin
    ld_data_o = '0;
    case (op_i)
      LSU_LB:  ld_data_o = {{(XLEN-8){ld_word[7]}}, ld_word[7:0]};
      LSU_LH:  ld_data_o = {{(XLEN-16){ld_word[15]}}, ld_word[15:0]};
      LSU_LBU: ld_data_o = {{(XLEN-8){1'b0}}, ld_word[7:0]};
      LSU_LHU: ld_data_o = {{(XLEN-16){1'b0}}, ld_word[15:0]};
      LSU_LW:  ld_data_o = XLEN'(ld_word);
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_axil.sv
`default_nettype none
// ============================================================================
// Module  : lsu_axil
// Purpose : Single-outstanding load/store unit between EXU and WBU, mastering
//           one AXI4-Lite port. Loads run AR then R, stores run AW/W (either
//           order or together) then B, non-memory ops pass in_addr straight
//           to the result.
// Ports   : clk - clock
//           rst - synchronous active-high reset
//           bus - lsu_axil_if.master (EXU request, WBU result, AXI4-Lite)
// Options : LSU_MISALIGN_CHECK_EN - when defined, misaligned half/word
//           accesses bypass the bus and complete with out_err=1.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_axil
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BUS_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  lsu_axil_if.master  bus
);

  localparam int STRB_W = BUS_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [BUS_W-1:0]  st_wdata;
  logic [STRB_W-1:0] st_wstrb;
  logic [XLEN-1:0]   ld_data;
  logic              misaligned;

  lsu_lane #(
    .XLEN  (XLEN),
    .BUS_W (BUS_W)
  ) u_lane (
    .op_i      (op_q),
    .off_i     (addr_q[OFF_W-1:0]),
    .st_data_i (wdata_q),
    .ld_bus_i  (bus.rdata),
    .wdata_o   (st_wdata),
    .wstrb_o   (st_wstrb),
    .ld_data_o (ld_data)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.in_op)
      LSU_LH, LSU_LHU, LSU_SH: misaligned = bus.in_addr[0];
      LSU_LW, LSU_SW:          misaligned = (bus.in_addr[1:0] != 2'b00);
      default: ;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d      = bus.in_op;
          addr_d    = bus.in_addr;
          wdata_d   = bus.in_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          if (misaligned) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (is_load(bus.in_op)) begin
            state_d = S_AR;
          end else if (is_store(bus.in_op)) begin
            state_d = S_W;
          end else begin
            data_d  = bus.in_addr;
            state_d = S_DONE;
          end
        end
      end

      S_AR: begin
        if (bus.arready) state_d = S_R;
      end

      S_R: begin
        if (bus.rvalid) begin
          data_d  = ld_data;
          err_d   = (bus.rresp != AXI_OKAY);
          state_d = S_DONE;
        end
      end

      // Each flag is sticky so its valid drops after its own handshake while
      // the other channel may still be waiting.
      S_W: begin
        if (bus.awready) aw_done_d = 1'b1;
        if (bus.wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_B;
      end

      S_B: begin
        if (bus.bvalid) begin
          data_d  = '0;
          err_d   = (bus.bresp != AXI_OKAY);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.arvalid   = (state_q == S_AR);
  assign bus.araddr    = addr_q;
  assign bus.rready    = (state_q == S_R);
  assign bus.awvalid   = (state_q == S_W) && !aw_done_q;
  assign bus.awaddr    = addr_q;
  assign bus.wvalid    = (state_q == S_W) && !w_done_q;
  assign bus.wdata     = st_wdata;
  assign bus.wstrb     = st_wstrb;
  assign bus.bready    = (state_q == S_B);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_axil.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_axil
// Purpose : Directed self-checking bench for lsu_axil (XLEN=32, BUS_W=64).
//           The bus responder behaves as a registered slave: ready rises a
//           configurable number of cycles after valid is first seen, and the
//           R/B response appears the cycle after the address/data handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_axil;
  import lsu_pkg::*;

  localparam int XLEN  = 32;
  localparam int BUS_W = 64;

  logic clk = 1'b0;
  logic rst;

  lsu_axil_if #(.XLEN(XLEN), .BUS_W(BUS_W)) bus ();

  lsu_axil #(.XLEN(XLEN), .BUS_W(BUS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // responder configuration
  int          ar_lat, aw_lat, w_lat, ordy_lat;
  logic [63:0] rd_bus;
  logic [1:0]  r_resp, b_resp;

  // per-op observations
  int          res_lat;
  logic [31:0] res_data;
  logic        res_err;
  int          n_ar, n_r, n_aw, n_w, n_b;
  bit          bus_seen;
  int          ar_unstable, hold_viol;
  logic [63:0] w_data_cap;
  logic [7:0]  w_strb_cap;
  logic [31:0] aw_addr_cap;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cfg_default();
    ar_lat = 1; aw_lat = 1; w_lat = 1; ordy_lat = 0;
    rd_bus = '0; r_resp = 2'b00; b_resp = 2'b00;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    bit ev_acc = 0, ev_ar = 0, ev_r = 0, ev_aw = 0, ev_w = 0, ev_b = 0, ev_out = 0;
    bit aw_hs = 0, w_hs = 0, b_issued = 0, seen_out = 0, done = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, ordy_cnt = 0, since = 0;
    res_lat = -1; res_data = '0; res_err = 1'b0;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
    bus_seen = 0; ar_unstable = 0; hold_viol = 0;
    w_data_cap = '0; w_strb_cap = '0; aw_addr_cap = '0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_addr = addr; bus.in_wdata = wd;
    for (int cyc = 0; cyc < 100; cyc++) begin
      // effects of the handshakes at the edge just passed
      if (ev_acc) begin bus.in_valid = 1'b0; since = 1; end
      if (ev_ar) begin
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = rd_bus; bus.rresp = r_resp;
      end
      if (ev_r)  bus.rvalid  = 1'b0;
      if (ev_aw) begin bus.awready = 1'b0; aw_hs = 1; end
      if (ev_w)  begin bus.wready  = 1'b0; w_hs  = 1; end
      if (ev_b)  bus.bvalid  = 1'b0;
      if (aw_hs && w_hs && !b_issued) begin
        bus.bvalid = 1'b1; bus.bresp = b_resp; b_issued = 1;
      end
      if (ev_out) begin bus.out_ready = 1'b0; done = 1; break; end
      // registered-ready slaves
      if (bus.arvalid) begin
        bus_seen = 1;
        if (bus.araddr !== addr) ar_unstable++;
        if (ar_cnt >= ar_lat) bus.arready = 1'b1;
        ar_cnt++;
      end
      if (bus.awvalid) begin
        bus_seen = 1;
        if (aw_cnt >= aw_lat) bus.awready = 1'b1;
        aw_cnt++;
      end
      if (bus.wvalid) begin
        bus_seen = 1;
        if (w_cnt >= w_lat) bus.wready = 1'b1;
        w_cnt++;
      end
      // WBU side: result must stay put until accepted
      if (bus.out_valid) begin
        if (!seen_out) begin
          seen_out = 1; res_lat = since; res_data = bus.out_data; res_err = bus.out_err;
        end else if (bus.out_data !== res_data || bus.out_err !== res_err || bus.in_ready !== 1'b0) begin
          hold_viol++;
        end
        if (ordy_cnt >= ordy_lat) bus.out_ready = 1'b1;
        ordy_cnt++;
      end else if (seen_out) begin
        hold_viol++;
      end
      // handshakes that fire at the next edge
      ev_acc = bus.in_valid && bus.in_ready;
      ev_ar  = bus.arvalid && bus.arready;
      ev_r   = bus.rvalid && bus.rready;
      ev_aw  = bus.awvalid && bus.awready;
      ev_w   = bus.wvalid && bus.wready;
      ev_b   = bus.bvalid && bus.bready;
      ev_out = bus.out_valid && bus.out_ready;
      if (ev_ar) n_ar++;
      if (ev_r)  n_r++;
      if (ev_aw) begin n_aw++; aw_addr_cap = bus.awaddr; end
      if (ev_w)  begin n_w++; w_data_cap = bus.wdata; w_strb_cap = bus.wstrb; end
      if (ev_b)  n_b++;
      if (since > 0) since++;
      @(negedge clk);
    end
    check_eq({tag, " done"}, 64'(done), 64'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_addr = '0; bus.in_wdata = '0;
    bus.out_ready = 1'b0; bus.arready = 1'b0; bus.rdata = '0; bus.rresp = '0;
    bus.rvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = '0;
    bus.bvalid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst vld", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                         bus.out_valid, bus.in_ready}, 7'b0000001);
    check_eq("rst data", bus.out_data, 0);
    check_eq("rst err", bus.out_err, 0);
    rst = 1'b0;

    // lb, top byte of the low word, sign extended
    cfg_default(); rd_bus = 64'h0000_0000_80FF_1234;
    run_op(LSU_LB, 32'h8000_0003, 32'h0, "lb");
    check_eq("lb data", res_data, 32'hFFFF_FF80);
    check_eq("lb err", res_err, 0);
    check_eq("lb lat", res_lat, 4);
    check_eq("lb ar hs", n_ar, 1);
    check_eq("lb araddr", ar_unstable, 0);
    check_eq("lb no aw", n_aw, 0);

    // sh in the top lanes, AW lagging W by three cycles
    cfg_default(); aw_lat = 4;
    run_op(LSU_SH, 32'h8000_0006, 32'h0000_ABCD, "sh");
    check_eq("sh wstrb", w_strb_cap, 8'hC0);
    check_eq("sh wdata hi", w_data_cap[63:48], 16'hABCD);
    check_eq("sh aw hs", n_aw, 1);
    check_eq("sh w hs", n_w, 1);
    check_eq("sh b hs", n_b, 1);
    check_eq("sh awaddr", aw_addr_cap, 32'h8000_0006);
    check_eq("sh data", res_data, 0);
    check_eq("sh err", res_err, 0);
    check_eq("sh lat", res_lat, 7);

    // lhu with a slow AR slave
    cfg_default(); ar_lat = 5; rd_bus = 64'h0000_0000_9ABC_0000;
    run_op(LSU_LHU, 32'h0000_0002, 32'h0, "lhu");
    check_eq("lhu data", res_data, 32'h0000_9ABC);
    check_eq("lhu araddr", ar_unstable, 0);
    check_eq("lhu ar hs", n_ar, 1);
    check_eq("lhu lat", res_lat, 8);

    // sw with SLVERR and a stalling WBU
    cfg_default(); b_resp = 2'b10; ordy_lat = 3;
    run_op(LSU_SW, 32'h0000_0010, 32'h1234_5678, "sw");
    check_eq("sw err", res_err, 1);
    check_eq("sw data", res_data, 0);
    check_eq("sw hold", hold_viol, 0);
    check_eq("sw wstrb", w_strb_cap, 8'h0F);
    check_eq("sw wdata", w_data_cap, 64'h1234_5678_1234_5678);
    check_eq("sw lat", res_lat, 4);
    check_eq("sw err clr", bus.out_err, 0);
    check_eq("sw idle", bus.in_ready, 1);

    // non-memory op passes the address through
    cfg_default();
    run_op(4'd9, 32'h0000_1234, 32'hFFFF_FFFF, "pass");
    check_eq("pass bus", bus_seen, 0);
    check_eq("pass lat", res_lat, 1);
    check_eq("pass data", res_data, 32'h0000_1234);
    check_eq("pass err", res_err, 0);

    // upper-word loads
    cfg_default(); rd_bus = 64'h0000_8001_0000_0000;
    run_op(LSU_LH, 32'h0000_0004, 32'h0, "lh");
    check_eq("lh data", res_data, 32'hFFFF_8001);
    cfg_default(); rd_bus = 64'h0000_F100_0000_0000;
    run_op(LSU_LBU, 32'h0000_0005, 32'h0, "lbu");
    check_eq("lbu data", res_data, 32'h0000_00F1);
    cfg_default(); rd_bus = 64'hDEAD_BEEF_0000_0000; r_resp = 2'b11;
    run_op(LSU_LW, 32'h0000_0004, 32'h0, "lw");
    check_eq("lw data", res_data, 32'hDEAD_BEEF);
    check_eq("lw err", res_err, 1);

    // sb replicates the byte, strobe on lane 3
    cfg_default();
    run_op(LSU_SB, 32'h0000_0003, 32'h0000_00A5, "sb");
    check_eq("sb wstrb", w_strb_cap, 8'h08);
    check_eq("sb wdata", w_data_cap, 64'hA5A5_A5A5_A5A5_A5A5);

    // misaligned word load
    cfg_default(); rd_bus = 64'h1122_3344_5566_7788;
    run_op(LSU_LW, 32'h0000_0005, 32'h0, "mis");
`ifdef LSU_MISALIGN_CHECK_EN
    check_eq("mis bus", bus_seen, 0);
    check_eq("mis err", res_err, 1);
    check_eq("mis data", res_data, 0);
    check_eq("mis lat", res_lat, 1);
`else
    check_eq("mis ar hs", n_ar, 1);
    check_eq("mis data", res_data, 32'h0011_2233);
    check_eq("mis err", res_err, 0);
`endif

    // reset while waiting in R
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = LSU_LW; bus.in_addr = 32'h0000_0100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("rr arvalid", bus.arvalid, 1);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check_eq("rr in R", bus.rready, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rr vld", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                        bus.out_valid, bus.in_ready}, 7'b0000001);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_axil.md
Name: lsu_axil

Overview:
- Parametrised load/store unit between EXU and WBU; masters one AXI4-Lite port to the data memory/crossbar.
- Accepts one memory op per valid/ready handshake from EXU and drives full AR/R and AW/W/B handshakes with byte-lane steering.
- Returns sign- or zero-extended load data, or a store completion, to WBU.
- Adds a configurable bus width, independent AW/W completion, error responses, and pass-through of non-memory ops.

Parameters:
- XLEN, 32, core data width; width of addr, store data and result.
- BUS_W, 32, AXI data width; 32 or 64. STRB_W = BUS_W/8 and OFF_W = log2(STRB_W) are derived.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EXU has an op
- in_ready  out  1  LSU can accept; high only in IDLE
- in_op  in  4  0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw, 8-15 no memory access
- in_addr  in  XLEN  effective address; this is the pass-through value for non-memory ops
- in_wdata  in  XLEN  store data (rs2)
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts
- out_data  out  XLEN  load result, or in_addr for non-memory ops; 0 for stores
- out_err  out  1  bus error on this op
- araddr  out  XLEN; arvalid  out  1; arready  in  1
- rdata  in  BUS_W; rresp  in  2; rvalid  in  1; rready  out  1
- awaddr  out  XLEN; awvalid  out  1; awready  in  1
- wdata  out  BUS_W; wstrb  out  STRB_W; wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Clocking: one clock. Synchronous reset on rst=1 at the rising edge:
  - state IDLE;
  - all valid/ready outputs 0, except in_ready=1;
  - out_data 0, out_err 0.
  - A reset mid-transaction abandons the transaction; the bus slaves share rst.
- States: IDLE, AR, R, W, B, DONE.
- IDLE:
  - On in_valid&&in_ready, capture op, addr and wdata.
  - Next state: AR for loads, W for stores, DONE for ops 8-15, with out_data=in_addr.
- AR: arvalid=1, araddr=captured addr. Hold both stable until arready; then go to R.
- R: rready=1.
  - On rvalid: shifted = rdata >> (addr[OFF_W-1:0]*8).
  - Extract and extend per op: lb/lh sign-extend, lbu/lhu zero-extend, lw takes the low 32 bits.
  - out_err = (rresp!=0). Go to DONE.
- W: awvalid and wvalid asserted together, tracked by sticky aw_done/w_done flags.
  - Each valid drops the cycle after its own handshake.
  - Leave for B when both are done; the two handshakes may land in the same cycle or different cycles.
  - wdata = in_wdata replicated across lanes.
  - wstrb = base mask << addr[OFF_W-1:0], with base mask sb 1, sh 3, sw F.
- B: bready=1. On bvalid, out_err=(bresp!=0) and out_data=0. Go to DONE.
- DONE: out_valid=1; out_data and out_err held stable. On out_ready, go to IDLE and clear out_err.
- Latency with zero-wait slaves:
  - load: 4 cycles from accept to out_valid;
  - store: 4 cycles;
  - pass-through: 1 cycle.
- No new op is accepted until DONE is acknowledged (single outstanding).
- The address is not masked; the slave sees the full byte address. Lane selection uses only addr[OFF_W-1:0].

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - in IDLE, lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, skip the bus and go straight to DONE with out_err=1, out_data=0;
  - no bus valid is ever raised for that op.
- Undefined: misaligned ops are issued as-is. Data crossing the bus word is truncated to the lanes present.

Decomposition:
- Package lsu_pkg:
  - op encodings (LSU_LB..LSU_SW, LSU_NONE);
  - state enum;
  - AXI resp constants (OKAY=0, SLVERR=2, DECERR=3).
- Sub-module lsu_lane: combinational byte steering.
  - Store side: wstrb/wdata generation.
  - Load side: shift plus sign/zero extension, parametrised by XLEN/BUS_W.

Test Plan:
- BUS_W=32, lb at addr 0x80000003, rdata=0x80FF1234, rresp=0 -> out_data=0xFFFFFF80, out_err=0, out_valid 4 cycles after accept.
- BUS_W=64, sh addr 0x80000006, wdata 0x0000ABCD -> wstrb=0xC0, wdata[63:48]=0xABCD; awready delayed 3 cycles behind wready -> exactly one AW and one W handshake, then B.
- lhu addr 0x2, rdata=0x9ABC0000, arready held low 5 cycles -> araddr/arvalid stable throughout; out_data=0x00009ABC.
- sw with bresp=2 -> out_err=1, out_data=0; out_ready low 3 cycles -> out_valid/out_err held, in_ready=0.
- op=9, in_addr=0x1234 -> no bus valid raised, out_valid next cycle, out_data=0x1234; rst asserted while in R -> all valids 0 and in_ready=1 next cycle.
- With LSU_MISALIGN_CHECK_EN, lw addr 0x5 -> arvalid never rises; out_err=1 one cycle after accept.
